// File: rtl/cmd_decode_pkt.sv
// ----------------------------------------------------------------------------
// cmd_decode_pkt
//
// Decodes command frames arriving byte-by-byte from a UART receiver and drives
// the SDRAM write FIFO and the SDRAM controller's read/write triggers.
//
//   write frame : WR_CMD [len] payload[0..len-1] [csum]
//   read frame  : RD_CMD [len]
//
// [len] is present only when LEN_MODE=1. Otherwise the length is PAYLOAD_LEN.
// [csum] is present only when CMD_CHECKSUM_EN is defined. It is the XOR of
// all payload bytes.
//
// An open frame is abandoned when TIMEOUT_CYC cycles pass without a byte.
// Payload bytes pushed before an abort stay in the FIFO. Downstream treats
// anything not followed by wr_trig as uncommitted.
//
// Optional feature macro: CMD_CHECKSUM_EN (adds the trailing checksum byte).
//
// Ports
//   sclk        in   system clock
//   reset       in   asynchronous active-low reset
//   uart_flag   in   one-cycle strobe, uart_data valid
//   uart_data   in   received byte
//   wfifo_wr_en out  write FIFO push strobe
//   wfifo_data  out  payload byte to write FIFO
//   wr_trig     out  pulse: write frame committed
//   wr_len      out  committed write byte count (valid with wr_trig)
//   rd_trig     out  pulse: read request
//   rd_len      out  requested read byte count (valid with rd_trig)
//   cmd_err     out  pulse: frame aborted or rejected
//
// All outputs are registered. Every output event appears one sclk after the
// uart_flag cycle (or timeout cycle) that causes it.
// ----------------------------------------------------------------------------
module cmd_decode_pkt #(
    parameter logic [7:0] WR_CMD      = 8'h55,
    parameter logic [7:0] RD_CMD      = 8'hAA,
    parameter int         LEN_MODE    = 0,
    parameter int         PAYLOAD_LEN = 4,
    parameter int         MAX_LEN     = 64,
    parameter int         LEN_W       = 8,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             uart_flag,
    input  logic [7:0]       uart_data,
    output logic             wfifo_wr_en,
    output logic [7:0]       wfifo_data,
    output logic             wr_trig,
    output logic [LEN_W-1:0] wr_len,
    output logic             rd_trig,
    output logic [LEN_W-1:0] rd_len,
    output logic             cmd_err
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LEN,
        S_WR_DATA,
        S_RD_LEN
`ifdef CMD_CHECKSUM_EN
        , S_WR_CSUM
`endif
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_len, w_len_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [TW-1:0]    r_timer, w_timer_nxt;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]       r_csum, w_csum_nxt;
`endif

    logic             r_wfifo_wr_en, w_wfifo_wr_en_nxt;
    logic [7:0]       r_wfifo_data, w_wfifo_data_nxt;
    logic             r_wr_trig, w_wr_trig_nxt;
    logic [LEN_W-1:0] r_wr_len, w_wr_len_nxt;
    logic             r_rd_trig, w_rd_trig_nxt;
    logic [LEN_W-1:0] r_rd_len, w_rd_len_nxt;
    logic             r_cmd_err, w_cmd_err_nxt;

    logic             w_timeout;
    logic             w_len_ok;

    // A byte in the timeout cycle wins, so the timeout only fires with no flag.
    assign w_timeout = (r_state != S_IDLE) && !uart_flag &&
                       (r_timer == TW'(TIMEOUT_CYC - 1));
    assign w_len_ok  = (uart_data != 8'd0) && (int'(uart_data) <= MAX_LEN);
    assign w_cnt_inc = r_cnt + CW'(1);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt       = r_state;
        w_len_nxt         = r_len;
        w_cnt_nxt         = r_cnt;
        w_timer_nxt       = '0;
`ifdef CMD_CHECKSUM_EN
        w_csum_nxt        = r_csum;
`endif
        w_wfifo_wr_en_nxt = 1'b0;
        w_wfifo_data_nxt  = '0;
        w_wr_trig_nxt     = 1'b0;
        w_wr_len_nxt      = '0;
        w_rd_trig_nxt     = 1'b0;
        w_rd_len_nxt      = '0;
        w_cmd_err_nxt     = 1'b0;

        if (r_state != S_IDLE && !uart_flag) begin
            w_timer_nxt = r_timer + TW'(1);
        end

        if (w_timeout) begin
            w_cmd_err_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_timer_nxt   = '0;
        end else if (uart_flag) begin
            case (r_state)
                S_IDLE: begin
                    if (uart_data == WR_CMD) begin
                        w_cnt_nxt = '0;
`ifdef CMD_CHECKSUM_EN
                        w_csum_nxt = '0;
`endif
                        if (LEN_MODE != 0) begin
                            w_state_nxt = S_WR_LEN;
                        end else begin
                            w_len_nxt   = CW'(PAYLOAD_LEN);
                            w_state_nxt = S_WR_DATA;
                        end
                    end else if (uart_data == RD_CMD) begin
                        if (LEN_MODE != 0) begin
                            w_state_nxt = S_RD_LEN;
                        end else begin
                            w_rd_trig_nxt = 1'b1;
                            w_rd_len_nxt  = LEN_W'(PAYLOAD_LEN);
                        end
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
                S_WR_LEN: begin
                    if (w_len_ok) begin
                        w_len_nxt   = CW'(uart_data);
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WR_DATA;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end
                S_RD_LEN: begin
                    if (w_len_ok) begin
                        w_rd_trig_nxt = 1'b1;
                        w_rd_len_nxt  = LEN_W'(uart_data);
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
                S_WR_DATA: begin
                    // Payload bytes are never decoded as commands.
                    w_wfifo_wr_en_nxt = 1'b1;
                    w_wfifo_data_nxt  = uart_data;
                    w_cnt_nxt         = w_cnt_inc;
`ifdef CMD_CHECKSUM_EN
                    w_csum_nxt        = r_csum ^ uart_data;
                    if (w_cnt_inc == r_len) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WR_CSUM;
                    end
`else
                    if (w_cnt_inc == r_len) begin
                        w_wr_trig_nxt = 1'b1;
                        w_wr_len_nxt  = LEN_W'(r_len);
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_IDLE;
                    end
`endif
                end
`ifdef CMD_CHECKSUM_EN
                S_WR_CSUM: begin
                    if (uart_data == r_csum) begin
                        w_wr_trig_nxt = 1'b1;
                        w_wr_len_nxt  = LEN_W'(r_len);
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples values from before the clock edge, whatever the block order.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_cnt         <= '0;
            r_timer       <= '0;
`ifdef CMD_CHECKSUM_EN
            r_csum        <= '0;
`endif
            r_wfifo_wr_en <= 1'b0;
            r_wfifo_data  <= '0;
            r_wr_trig     <= 1'b0;
            r_wr_len      <= '0;
            r_rd_trig     <= 1'b0;
            r_rd_len      <= '0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timer       <= w_timer_nxt;
`ifdef CMD_CHECKSUM_EN
            r_csum        <= w_csum_nxt;
`endif
            r_wfifo_wr_en <= w_wfifo_wr_en_nxt;
            r_wfifo_data  <= w_wfifo_data_nxt;
            r_wr_trig     <= w_wr_trig_nxt;
            r_wr_len      <= w_wr_len_nxt;
            r_rd_trig     <= w_rd_trig_nxt;
            r_rd_len      <= w_rd_len_nxt;
            r_cmd_err     <= w_cmd_err_nxt;
        end
    end

    assign wfifo_wr_en = r_wfifo_wr_en;
    assign wfifo_data  = r_wfifo_data;
    assign wr_trig     = r_wr_trig;
    assign wr_len      = r_wr_len;
    assign rd_trig     = r_rd_trig;
    assign rd_len      = r_rd_len;
    assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_cmd_decode_pkt.sv
// ----------------------------------------------------------------------------
// tb_cmd_decode_pkt
//
// Instance 0 runs with LEN_MODE=0 and instance 1 with LEN_MODE=1. Both use
// TIMEOUT_CYC=1000. A frame-level reference model parses the bytes each
// instance has received so far. It pushes the expected output events, stamped
// with their cycle, into a per-instance queue. A monitor on the falling edge
// pops one event whenever an instance shows activity and compares it.
// ----------------------------------------------------------------------------
module tb_cmd_decode_pkt;

    localparam int         TMO  = 1000;
    localparam int         PLEN = 4;
    localparam int         MAXL = 64;
    localparam logic [7:0] WRC  = 8'h55;
    localparam logic [7:0] RDC  = 8'hAA;
`ifdef CMD_CHECKSUM_EN
    localparam bit         CSUM = 1'b1;
`else
    localparam bit         CSUM = 1'b0;
`endif

    typedef struct {
        int         cyc;
        bit         push;
        logic [7:0] data;
        bit         wr;
        int         wlen;
        bit         rd;
        int         rlen;
        bit         err;
    } ev_t;

    logic       sclk = 1'b0;
    logic       reset;
    logic       flag [2];
    logic [7:0] data [2];
    logic       wen  [2];
    logic [7:0] wdat [2];
    logic       wtr  [2];
    logic [7:0] wlen [2];
    logic       rtr  [2];
    logic [7:0] rlen [2];
    logic       err  [2];

    ev_t        exp_q   [2][$];
    logic [7:0] frame_q [2][$];
    int         last_cyc [2];
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q [$];

    always #10 sclk = ~sclk;

    cmd_decode_pkt #(.LEN_MODE(0), .PAYLOAD_LEN(PLEN), .MAX_LEN(MAXL),
                     .LEN_W(8), .TIMEOUT_CYC(TMO)) dut0 (
        .sclk(sclk), .reset(reset), .uart_flag(flag[0]), .uart_data(data[0]),
        .wfifo_wr_en(wen[0]), .wfifo_data(wdat[0]), .wr_trig(wtr[0]),
        .wr_len(wlen[0]), .rd_trig(rtr[0]), .rd_len(rlen[0]), .cmd_err(err[0]));

    cmd_decode_pkt #(.LEN_MODE(1), .PAYLOAD_LEN(PLEN), .MAX_LEN(MAXL),
                     .LEN_W(8), .TIMEOUT_CYC(TMO)) dut1 (
        .sclk(sclk), .reset(reset), .uart_flag(flag[1]), .uart_data(data[1]),
        .wfifo_wr_en(wen[1]), .wfifo_data(wdat[1]), .wr_trig(wtr[1]),
        .wr_len(wlen[1]), .rd_trig(rtr[1]), .rd_len(rlen[1]), .cmd_err(err[1]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit len_legal(input logic [7:0] l);
        return (l != 8'd0) && (int'(l) <= MAXL);
    endfunction

    // Reference model: append the byte to the open frame and decide from the
    // frame contents what, if anything, this byte produces.
    task automatic model_byte(input int i, input logic [7:0] b);
        ev_t        e;
        int         sz, hdr, n;
        logic [7:0] cmd, x;
        bit         done, mode;
        mode  = (i == 1);
        e     = '{default: 0};
        e.cyc = cyc;
        frame_q[i].push_back(b);
        sz   = frame_q[i].size();
        cmd  = frame_q[i][0];
        done = 1'b0;
        if (cmd == RDC) begin
            if (!mode) begin
                e.rd = 1; e.rlen = PLEN; done = 1;
            end else if (sz == 2) begin
                if (len_legal(b)) begin e.rd = 1; e.rlen = int'(b); end
                else e.err = 1;
                done = 1;
            end
        end else if (cmd == WRC) begin
            hdr = mode ? 2 : 1;
            if (sz > 1) begin
                if (mode && sz == 2) begin
                    if (!len_legal(b)) begin e.err = 1; done = 1; end
                end else begin
                    n = mode ? int'(frame_q[i][1]) : PLEN;
                    if (sz <= hdr + n) begin
                        e.push = 1; e.data = b;
                        if (sz == hdr + n && !CSUM) begin
                            e.wr = 1; e.wlen = n; done = 1;
                        end
                    end else begin
                        x = 8'h00;
                        for (int k = hdr; k < hdr + n; k++) x ^= frame_q[i][k];
                        if (x == b) begin e.wr = 1; e.wlen = n; end
                        else e.err = 1;
                        done = 1;
                    end
                end
            end
        end else begin
            e.err = 1; done = 1;
        end
        if (done) frame_q[i].delete();
        if (e.push || e.wr || e.rd || e.err) exp_q[i].push_back(e);
    endtask

    // Model clock: one step per rising edge, including the timeout rule.
    initial forever begin
        @(posedge sclk);
        cyc++;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (flag[i]) begin
                    last_cyc[i] = cyc;
                    model_byte(i, data[i]);
                end else if (frame_q[i].size() > 0 && cyc - last_cyc[i] == TMO) begin
                    ev_t e;
                    e = '{default: 0};
                    e.cyc = cyc;
                    e.err = 1;
                    exp_q[i].push_back(e);
                    frame_q[i].delete();
                end
            end
        end
    end

    // Monitor: compare DUT activity against the queued expectations.
    initial forever begin
        @(negedge sclk);
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
                    ev_t m;
                    m = exp_q[i].pop_front();
                    checks++; failures++;
                    $display("FAIL missed_event[%0d] at cyc=%0d required push=%0b data=%02h wr=%0b wlen=%0d rd=%0b rlen=%0d err=%0b actual none",
                             i, m.cyc, m.push, m.data, m.wr, m.wlen, m.rd, m.rlen, m.err);
                end
                if (wen[i] || wtr[i] || rtr[i] || err[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        failures++;
                        $display("FAIL spurious_event[%0d] cyc=%0d actual push=%0b data=%02h wr=%0b wlen=%0d rd=%0b rlen=%0d err=%0b required none",
                                 i, cyc, wen[i], wdat[i], wtr[i], wlen[i], rtr[i], rlen[i], err[i]);
                    end else begin
                        ev_t e;
                        bit  ok;
                        e  = exp_q[i].pop_front();
                        ok = (e.cyc == cyc) && (e.push == wen[i]) && (!e.push || e.data == wdat[i]) &&
                             (e.wr == wtr[i]) && (!e.wr || e.wlen == int'(wlen[i])) &&
                             (e.rd == rtr[i]) && (!e.rd || e.rlen == int'(rlen[i])) &&
                             (e.err == err[i]);
                        if (!ok) begin
                            failures++;
                            $display("FAIL event[%0d] actual cyc=%0d push=%0b data=%02h wr=%0b wlen=%0d rd=%0b rlen=%0d err=%0b required cyc=%0d push=%0b data=%02h wr=%0b wlen=%0d rd=%0b rlen=%0d err=%0b",
                                     i, cyc, wen[i], wdat[i], wtr[i], wlen[i], rtr[i], rlen[i], err[i],
                                     e.cyc, e.push, e.data, e.wr, e.wlen, e.rd, e.rlen, e.err);
                        end
                    end
                end
            end
        end
    end

    // Gap = idle cycles before the byte; a byte at edge c with gap g is
    // followed by the next byte at edge c+g+1.
    task automatic send_byte(input int i, input logic [7:0] b, input int gap);
        repeat (gap) begin
            flag[i] = 1'b0;
            @(negedge sclk);
        end
        flag[i] = 1'b1;
        data[i] = b;
        @(negedge sclk);
        flag[i] = 1'b0;
        data[i] = 8'($urandom);
    endtask

    task automatic send_q(input int i, input logic [7:0] s[$], input int gap);
        foreach (s[k]) send_byte(i, s[k], gap);
    endtask

    // Complete, valid write frame for instance i (adds length and checksum).
    task automatic wr_frame(input int i, input logic [7:0] pl[$], input int gap);
        logic [7:0] s[$];
        logic [7:0] x;
        x = 8'h00;
        s.push_back(WRC);
        if (i == 1) s.push_back(8'(pl.size()));
        foreach (pl[k]) begin
            s.push_back(pl[k]);
            x ^= pl[k];
        end
        if (CSUM) s.push_back(x);
        send_q(i, s, gap);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return WRC;
        if (r == 1) return RDC;
        return 8'($urandom);
    endfunction

    task automatic random_frame();
        logic [7:0] s[$];
        logic [7:0] x;
        int         i, sel, n, long_at;
        i   = $urandom_range(0, 1);
        sel = $urandom_range(0, 9);
        if ($urandom_range(0, 4) == 0)      n = $urandom_range(60, 70);
        else if ($urandom_range(0, 9) == 0) n = 0;
        else                                n = $urandom_range(1, 12);
        if (i == 0) n = PLEN;
        if (sel <= 4 || sel == 9) begin
            s.push_back(WRC);
            if (i == 1) s.push_back(8'(n));
            if (i == 0 || len_legal(8'(n))) begin
                x = 8'h00;
                for (int k = 0; k < n; k++) begin
                    s.push_back(rand_byte());
                    x ^= s[s.size() - 1];
                end
                if (CSUM) s.push_back(($urandom_range(0, 4) == 0) ? ~x : x);
                if (sel == 9 && s.size() > 2) s = s[0:s.size() - 2];
            end
        end else if (sel <= 7) begin
            s.push_back(RDC);
            if (i == 1) s.push_back(8'(n));
        end else begin
            s.push_back(rand_byte());
        end
        long_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, s.size() - 1) : -1;
        foreach (s[k]) begin
            if (k == long_at) send_byte(i, s[k], $urandom_range(TMO - 2, TMO + 1));
            else              send_byte(i, s[k], $urandom_range(0, 4));
        end
        if (sel == 9) repeat (TMO + 3) @(negedge sclk);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            flag[i] = 1'b0; data[i] = 8'h00; last_cyc[i] = 0;
        end
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_outputs[%0d]", i),
                  int'({wen[i], wtr[i], rtr[i], err[i], wdat[i], wlen[i], rlen[i]}), 0);
        repeat (3) @(negedge sclk);
        reset = 1'b1;
        @(negedge sclk);

        // Fixed-length mode: two identical write frames, read, idle junk.
        q = {8'h12, 8'h34, 8'h56, 8'h78};
        wr_frame(0, q, 3);
        wr_frame(0, q, 0);
        send_byte(0, RDC, 3);
        send_byte(0, 8'h3C, 3);
        // Checksum-style trailers.
        q = {WRC, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_q(0, q, 2);
        q = {WRC, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_q(0, q, 2);
        repeat (5) @(negedge sclk);

        // Length mode: command bytes inside payload, reads, length limits.
        q = {RDC, WRC, 8'h01};
        wr_frame(1, q, 2);
        q = {RDC, 8'h10, WRC, 8'h00, WRC, 8'h41, RDC, 8'h00, RDC, 8'h40, RDC, 8'h41};
        send_q(1, q, 1);
        q = {8'h7E};
        wr_frame(1, q, 0);
        q = {WRC, 8'd64};
        send_q(1, q, 1);
        for (int k = 0; k < 64; k++) send_byte(1, 8'(k * 7), 0);
        if (CSUM) send_byte(1, 8'h00, 0);

        // Timeout boundary: a gap of TMO-1 survives, a gap of TMO aborts.
        q = {WRC, 8'h02};
        send_q(1, q, 1);
        send_byte(1, 8'hAB, TMO - 1);
        send_byte(1, 8'hCD, TMO - 1);
        if (CSUM) send_byte(1, 8'hAB ^ 8'hCD, TMO - 1);
        q = {WRC, 8'h02};
        send_q(1, q, 1);
        send_byte(1, 8'h11, TMO);
        repeat (5) @(negedge sclk);

        // Timeout mid-frame, then a normal frame.
        q = {WRC, 8'h12, 8'h34};
        send_q(0, q, 2);
        repeat (2000) @(negedge sclk);
        q = {8'h12, 8'h34, 8'h56, 8'h78};
        wr_frame(0, q, 2);
        repeat (5) @(negedge sclk);

        // Reset in the middle of a frame, while a push is on the outputs.
        q = {WRC, 8'h12};
        send_q(0, q, 2);
        check("push_before_reset", int'(wen[0]), 1);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("midframe_reset_outputs[%0d]", i),
                  int'({wen[i], wtr[i], rtr[i], err[i], wdat[i], wlen[i], rlen[i]}), 0);
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            frame_q[i].delete();
        end
        repeat (2) @(negedge sclk);
        reset = 1'b1;
        q = {8'h34, 8'h56, 8'h78};
        send_q(0, q, 2);

        // Randomised frames across both instances.
        for (int f = 0; f < 100; f++) random_frame();

        repeat (TMO + 20) @(negedge sclk);
        for (int i = 0; i < 2; i++)
            check($sformatf("pending_events[%0d]", i), exp_q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_decode_pkt.md
Name: cmd_decode_pkt

Overview:
Parametrised successor to the fixed 5-byte UART command decoder. Consumes bytes from uart_rx (uart_flag/uart_data) and recognises write and read command frames. Streams write payload into the SDRAM write FIFO and issues wr_trig/rd_trig with burst lengths to the SDRAM controller. Adds variable-length frames, an inter-byte timeout and error reporting.

Parameters:
WR_CMD, 8'h55, write command byte
RD_CMD, 8'hAA, read command byte
LEN_MODE, 0, 0 = fixed PAYLOAD_LEN; 1 = byte after command carries length
PAYLOAD_LEN, 4, write/read burst length in bytes when LEN_MODE=0 (1..MAX_LEN)
MAX_LEN, 64, largest legal length in LEN_MODE=1
LEN_W, 8, width of wr_len/rd_len
TIMEOUT_CYC, 50000, max sclk cycles between bytes inside a frame (1 ms at 50 MHz)

Ports:
sclk  in  1  system clock, 50 MHz
reset  in  1  asynchronous active-low reset
uart_flag  in  1  one-cycle strobe, uart_data valid
uart_data  in  8  received byte
wfifo_wr_en  out  1  write FIFO push strobe
wfifo_data  out  8  payload byte to write FIFO
wr_trig  out  1  one-cycle pulse: write frame complete and valid
wr_len  out  LEN_W  byte count of committed write, valid while wr_trig=1
rd_trig  out  1  one-cycle pulse: read request
rd_len  out  LEN_W  requested read byte count, valid while rd_trig=1
cmd_err  out  1  one-cycle pulse: frame aborted or rejected

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, byte counter 0, timer 0.
- All outputs registered; every output event occurs exactly 1 sclk after the uart_flag cycle that causes it.
- States: IDLE, WR_LEN, WR_DATA, WR_CSUM (feature only), RD_LEN.
- IDLE: uart_data==WR_CMD -> WR_LEN (LEN_MODE=1) or WR_DATA with len=PAYLOAD_LEN. uart_data==RD_CMD -> RD_LEN (LEN_MODE=1), or in LEN_MODE=0 pulse rd_trig with rd_len=PAYLOAD_LEN and stay IDLE. Any other byte: pulse cmd_err, stay IDLE.
- WR_LEN/RD_LEN: length byte L; L==0 or L>MAX_LEN -> cmd_err, IDLE. Else latch L; WR_LEN -> WR_DATA; RD_LEN -> pulse rd_trig, rd_len=L, IDLE.
- WR_DATA: each uart_flag -> wfifo_wr_en=1, wfifo_data=uart_data for one cycle, count++. Payload bytes equal to WR_CMD/RD_CMD are data, not commands. On byte count==len: feature off -> pulse wr_trig with wr_len=len in the same cycle as the last wfifo_wr_en, go IDLE.
- Timeout: timer clears on each uart_flag, counts in every non-IDLE state; reaching TIMEOUT_CYC -> cmd_err pulse, IDLE, counter cleared, no wr_trig. Bytes already pushed stay in FIFO; downstream discards uncommitted data (commit = wr_trig).
- uart_flag in the timeout cycle: byte wins, timer clears.
- Counter width ceil(log2(MAX_LEN+1)); no wrap possible since len<=MAX_LEN.
- wr_trig, rd_trig, cmd_err mutually exclusive in any cycle.

Optional Feature:
CMD_CHECKSUM_EN: defined -> after last payload byte go to WR_CSUM; next byte compared to XOR of all payload bytes (length byte excluded). Match -> wr_trig + wr_len; mismatch -> cmd_err, no wr_trig. Last payload wfifo_wr_en then precedes wr_trig by one byte time. Timeout applies in WR_CSUM. Undefined -> no WR_CSUM state, wr_trig as above.

Test Plan:
- LEN_MODE=0, UART 115200 (8680 ns/bit): 55 12 34 56 78 -> four wfifo_wr_en pulses with data 12,34,56,78; wr_trig with wr_len=4 coincident with 4th push; then AA -> rd_trig, rd_len=4. Repeat frame twice, identical results.
- LEN_MODE=1: 55 03 AA 55 01 -> pushes AA,55,01 (no command decode), wr_trig wr_len=3; AA 10 -> rd_trig rd_len=16.
- Errors: idle byte 3C -> cmd_err, no other output; LEN_MODE=1, 55 00 -> cmd_err; 55 41 (MAX_LEN=64) -> cmd_err.
- Timeout: TIMEOUT_CYC=1000, send 55 12 34 then idle 2000 cycles -> two pushes, cmd_err once, no wr_trig; next full frame decodes normally.
- Reset mid-frame: assert reset after 55 12 -> outputs 0 immediately; after release, 34 56 78 -> cmd_err each (not in frame).
- CMD_CHECKSUM_EN: 55 12 34 56 78 08 -> wr_trig; same with 09 -> cmd_err, no wr_trig.
